// File: rtl/lsu_wb_stage_pkg.sv
// Shared definitions for the memory/write-back stage.
//  - register bus widths and the zero word
//  - execute-op kind encodings
//  - load/store funct3 codes
//  - FSM state encodings
//  - alignment helper used when a load/store is accepted
package lsu_wb_stage_pkg;

   localparam int REG_BUS_W  = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      KIND_ALU   = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2,
      KIND_NOP   = 2'd3
   } kind_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // funct3[1:0] carries the access size for both loads and stores:
   // bytes are always aligned, halves need addr[0]=0, words need addr[1:0]=00.
   function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   return 1'b1;
         2'b01:   return ~addr_lo[0];
         default: return (addr_lo == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_wb_stage_load_align.sv
// Load data alignment (combinational).
//  rdata   : raw read word from the data bus
//  addr_lo : byte offset of the load within the word
//  funct3  : load size/sign (LB, LH, LW, LBU, LHU)
//  data    : selected lane, sign- or zero-extended to the register width
module lsu_wb_stage_load_align
   import lsu_wb_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      // halfwords are only ever at offset 0 or 2 once alignment is enforced
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      case (funct3)
         F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   data = {24'd0, byte_lane};
         F3_H:    data = {{16{half_lane[15]}}, half_lane};
         F3_HU:   data = {16'd0, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_wb_stage.sv
// Memory/write-back stage.
//  Accepts one ALU/LOAD/STORE/NOP op per ex_valid & ex_ready handshake.
//  ALU results are written to the register file the next cycle; loads and stores
//  run one data-bus transaction (held stable until bus_ack), loads then spend one
//  WB cycle driving the write port. Misaligned accesses are dropped with a
//  one-cycle misalign pulse. we/waddr/wdata double as the forwarding source.
// Ports:
//  clk, rst (async, active low)
//  ex_valid/ex_ready/ex_kind/ex_funct3/ex_rd/ex_result/ex_sdata : execute-side op
//  bus_req/bus_we/bus_addr/bus_be/bus_wdata/bus_ack/bus_rdata   : data bus
//  we/waddr/wdata : register file write port; misalign : dropped-access pulse
module lsu_wb_stage
   import lsu_wb_stage_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = 32,
   parameter int REG_AW = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [1:0]        ex_kind,
   input  logic [2:0]        ex_funct3,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_sdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              we,
   output logic [REG_AW-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              misalign
);

   state_e state, state_next;

   logic              accept;
   kind_e             kind;
   logic              is_mem;
   logic              aligned;
   logic              start_bus;
   logic              drop_mem;
   logic              bus_done;

   logic              pend_load;
   logic [2:0]        pend_f3;
   logic [1:0]        pend_lo;
   logic [REG_AW-1:0] pend_rd;

   logic [3:0]        store_be;
   logic [DATA_W-1:0] store_data;
   logic [DATA_W-1:0] load_data;

   assign kind      = kind_e'(ex_kind);
   assign accept    = ex_valid & ex_ready;
   assign is_mem    = (kind == KIND_LOAD) || (kind == KIND_STORE);
   assign aligned   = is_aligned(ex_funct3, ex_result[1:0]);
   assign start_bus = accept & is_mem & aligned;
   assign drop_mem  = accept & is_mem & ~aligned;
   // ack only counts while a request is actually outstanding
   assign bus_done  = (state == ST_BUS) & bus_ack;

   // bus_req comes straight from the state so reset removes it without waiting for a clock
   assign bus_req = (state == ST_BUS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      ex_ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            ex_ready = 1'b1;
            if (start_bus) state_next = ST_BUS;
         end
         ST_BUS: begin
            if (bus_ack) state_next = pend_load ? ST_WB : ST_IDLE;
         end
         ST_WB:   state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Byte-lane steering: narrow stores are replicated across the word so the
   // byte enables alone select the target lane.
   always_comb begin
      store_be   = 4'b1111;
      store_data = ex_sdata;
      case (ex_funct3[1:0])
         2'b00: begin
            store_be   = 4'b0001 << ex_result[1:0];
            store_data = {4{ex_sdata[7:0]}};
         end
         2'b01: begin
            store_be   = 4'b0011 << ex_result[1:0];
            store_data = {2{ex_sdata[15:0]}};
         end
         default: begin
            store_be   = 4'b1111;
            store_data = ex_sdata;
         end
      endcase
   end

   lsu_wb_stage_load_align u_load_align (
      .rdata   (bus_rdata),
      .addr_lo (pend_lo),
      .funct3  (pend_f3),
      .data    (load_data)
   );

   // Transaction capture; values are frozen for the whole BUS state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_load <= 1'b0;
         pend_f3   <= 3'd0;
         pend_lo   <= 2'd0;
         pend_rd   <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'd0;
         bus_wdata <= '0;
      end else if (start_bus) begin
         pend_load <= (kind == KIND_LOAD);
         pend_f3   <= ex_funct3;
         pend_lo   <= ex_result[1:0];
         pend_rd   <= ex_rd;
         bus_we    <= (kind == KIND_STORE);
         bus_addr  <= {ex_result[ADDR_W-1:2], 2'b00};
         bus_be    <= (kind == KIND_STORE) ? store_be : 4'd0;
         bus_wdata <= (kind == KIND_STORE) ? store_data : '0;
      end
   end

   // Write port: we is a single-cycle strobe, suppressed for x0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= ZERO_WORD;
         misalign <= 1'b0;
      end else begin
         we       <= 1'b0;
         misalign <= drop_mem;
         if (accept && kind == KIND_ALU) begin
            we    <= (ex_rd != '0);
            waddr <= ex_rd;
            wdata <= ex_result;
         end else if (bus_done && pend_load) begin
            we    <= (pend_rd != '0);
            waddr <= pend_rd;
            wdata <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Randomized scoreboard bench for lsu_wb_stage. Stimulus pushes expected register
// writes, bus transactions and misalign pulses computed from the access rules;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_lsu_wb_stage;

   localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_NOP = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [1:0]  ex_kind = 2'd0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic [31:0] ex_result = 32'd0;
   logic [31:0] ex_sdata = 32'd0;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        misalign;

   always #5 clk = ~clk;

   lsu_wb_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_kind(ex_kind), .ex_funct3(ex_funct3),
      .ex_rd(ex_rd), .ex_result(ex_result), .ex_sdata(ex_sdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .we(we), .waddr(waddr), .wdata(wdata), .misalign(misalign)
   );

   typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
   typedef struct { logic [31:0] addr; logic wr; logic [3:0] be; logic [31:0] wdata; } bus_t;

   wr_t         wr_q[$];
   bus_t        bus_q[$];
   logic [31:0] rdata_q[$];
   int          misalign_exp = 0;
   int          compared = 0;
   int          mismatched = 0;
   bit          mon_en = 1'b0;
   bit          hold_ack = 1'b0;
   bus_t        cur_bus;
   bit          have_cur = 1'b0;
   bit          req_prev = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, actual, required, $time);
      end
   endtask

   function automatic int sizeOf(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // shift the addressed lane down, keep its width, then extend
   function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input int lo, input int nbytes, input bit sgn);
      logic [31:0] v, mask;
      v = rdata >> (8 * lo);
      if (nbytes == 4) return v;
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      v = v & mask;
      if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
      return v;
   endfunction

   // Present one op when the stage is ready and record what it must produce.
   task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] result, input logic [31:0] sdata, input logic [31:0] rdata);
      int   n, lo, waited;
      bus_t b;
      wr_t  w;
      waited = 0;
      forever begin
         @(negedge clk);
         if (ex_ready) break;
         // junk while busy must never be taken
         ex_valid  = 1'($urandom % 2);
         ex_kind   = K_ALU;
         ex_rd     = 5'($urandom_range(1, 31));
         ex_result = $urandom;
         waited++;
         if (waited > 100) begin
            checkOutput("ready_timeout", {31'd0, ex_ready}, 32'd1);
            ex_valid = 1'b0;
            return;
         end
      end
      ex_valid = 1'b1; ex_kind = kind; ex_funct3 = f3; ex_rd = rd;
      ex_result = result; ex_sdata = sdata;
      n  = sizeOf(f3);
      lo = int'(result[1:0]);
      if (kind == K_ALU) begin
         if (rd != 5'd0) begin w.rd = rd; w.data = result; wr_q.push_back(w); end
      end else if (kind == K_LOAD || kind == K_STORE) begin
         if ((lo % n) != 0) begin
            misalign_exp++;
         end else begin
            b.addr = result & 32'hFFFF_FFFC;
            b.wr   = (kind == K_STORE);
            b.be   = 4'd0;
            b.wdata = 32'd0;
            if (kind == K_STORE) begin
               for (int i = 0; i < 4; i++) begin
                  b.be[i] = (i >= lo) && (i < lo + n);
                  b.wdata[8*i +: 8] = sdata[8*(i % n) +: 8];
               end
            end else begin
               rdata_q.push_back(rdata);
               if (rd != 5'd0) begin
                  w.rd = rd; w.data = modelLoad(rdata, lo, n, !f3[2]); wr_q.push_back(w);
               end
            end
            bus_q.push_back(b);
         end
      end
      @(posedge clk);
      #1 ex_valid = 1'b0;
   endtask

   // Monitor: compares register writes, misalign pulses and bus transactions.
   always @(negedge clk) begin
      if (mon_en) begin
         if (we) begin
            if (wr_q.size() == 0) checkOutput("unexpected_we", {31'd0, we}, 32'd0);
            else begin
               wr_t e;
               e = wr_q.pop_front();
               checkOutput("waddr", {27'd0, waddr}, {27'd0, e.rd});
               checkOutput("wdata", wdata, e.data);
            end
         end
         if (misalign) begin
            checkOutput("misalign_expected", {31'd0, misalign_exp > 0}, 32'd1);
            if (misalign_exp > 0) misalign_exp--;
         end
         if (bus_req && !req_prev) begin
            if (bus_q.size() == 0) begin
               checkOutput("unexpected_bus_req", {31'd0, bus_req}, 32'd0);
               have_cur = 1'b0;
            end else begin
               cur_bus = bus_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (bus_req && have_cur) begin
            checkOutput("bus_addr", bus_addr, cur_bus.addr);
            checkOutput("bus_we", {31'd0, bus_we}, {31'd0, cur_bus.wr});
            checkOutput("bus_be", {28'd0, bus_be}, {28'd0, cur_bus.be});
            checkOutput("bus_wdata", bus_wdata, cur_bus.wdata);
         end
      end
      req_prev = bus_req;
   end

   // Bus responder: random wait states, spurious acks while idle, latency checks after ack.
   initial begin
      int  wait_left;
      bit  was_store;
      wait_left = -1;
      forever begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (bus_req && !hold_ack) begin
            if (wait_left < 0) wait_left = $urandom_range(0, 3);
            if (wait_left == 0) begin
               was_store = bus_we;
               if (was_store) bus_rdata = $urandom;
               else if (rdata_q.size() > 0) bus_rdata = rdata_q.pop_front();
               else bus_rdata = $urandom;
               bus_ack = 1'b1;
               wait_left = -1;
               @(negedge clk);
               bus_ack = 1'b0;
               bus_rdata = $urandom;
               checkOutput("req_after_ack", {31'd0, bus_req}, 32'd0);
               checkOutput("ready_after_ack", {31'd0, ex_ready}, {31'd0, was_store});
               if (!was_store) begin
                  @(negedge clk);
                  checkOutput("ready_after_wb", {31'd0, ex_ready}, 32'd1);
               end
            end else begin
               wait_left--;
            end
         end else if (!bus_req && !hold_ack) begin
            bus_ack   = ($urandom % 4 == 0);
            bus_rdata = $urandom;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0]  k;
      logic [2:0]  f3;
      int          drain;
      logic [2:0]  load_f3[5];
      load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
      load_f3[3] = 3'b100; load_f3[4] = 3'b101;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
      checkOutput("rst_we", {31'd0, we}, 32'd0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
      checkOutput("rst_bus_addr", bus_addr, 32'd0);
      checkOutput("rst_bus_be", {28'd0, bus_be}, 32'd0);
      checkOutput("rst_wdata", wdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mon_en = 1'b1;
      #1 checkOutput("idle_ready", {31'd0, ex_ready}, 32'd1);

      // directed cases
      applyStimulus(K_ALU, 3'd0, 5'd5, 32'h11, 32'd0, 32'd0);
      applyStimulus(K_ALU, 3'd0, 5'd6, 32'h22, 32'd0, 32'd0);
      applyStimulus(K_LOAD, 3'b000, 5'd9, 32'h1003, 32'd0, 32'h80FF_0000);
      applyStimulus(K_STORE, 3'b001, 5'd0, 32'h2002, 32'h0000_BEEF, 32'd0);
      applyStimulus(K_LOAD, 3'b010, 5'd10, 32'h3001, 32'd0, 32'd0);
      applyStimulus(K_ALU, 3'd0, 5'd0, 32'h1234, 32'd0, 32'd0);
      applyStimulus(K_LOAD, 3'b101, 5'd11, 32'h0002, 32'd0, 32'h8001_0000);
      applyStimulus(K_NOP, 3'd0, 5'd12, 32'h55, 32'd0, 32'd0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         k = 2'($urandom % 4);
         if (k == K_LOAD) f3 = load_f3[$urandom % 5];
         else f3 = 3'($urandom % 3);
         applyStimulus(k, f3, 5'($urandom), (k == K_ALU) ? $urandom : {20'h0, 12'($urandom)},
                       $urandom, $urandom);
      end

      // drain
      drain = 0;
      while ((wr_q.size() != 0 || bus_q.size() != 0 || misalign_exp != 0 || !ex_ready || bus_req) && drain < 200) begin
         @(negedge clk);
         drain++;
      end
      repeat (3) @(negedge clk);
      checkOutput("left_writes", 32'(wr_q.size()), 32'd0);
      checkOutput("left_bus", 32'(bus_q.size()), 32'd0);
      checkOutput("left_misalign", 32'(misalign_exp), 32'd0);

      // reset during a bus transaction: the pending load must never write
      hold_ack = 1'b1;
      applyStimulus(K_LOAD, 3'b010, 5'd7, 32'h0000_0400, 32'd0, 32'hCAFE_F00D);
      wr_q.delete();
      rdata_q.delete();
      @(negedge clk);
      @(negedge clk);
      checkOutput("req_in_bus", {31'd0, bus_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_req_drop", {31'd0, bus_req}, 32'd0);
      checkOutput("rst_we_drop", {31'd0, we}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      hold_ack = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", {31'd0, ex_ready}, 32'd1);
      checkOutput("post_rst_req", {31'd0, bus_req}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("post_rst_writes", 32'(wr_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
